// File: rtl/xbar_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : xbar_cfg
//  Purpose  : Parametrised N_IN-to-N_OUT input crossbar for a LUT tile. Each
//             output picks any input through a SEL_W-bit select field. Fields
//             are scanned serially into a shadow register and moved atomically
//             into the active register by a commit pulse, so the routing never
//             changes while a new configuration is being shifted in.
//  Ports    : clk              - clock
//             reset            - asynchronous active-high reset
//             io_xbar_in       - crossbar data inputs  [N_IN-1:0]
//             io_xbar_out      - crossbar data outputs [N_OUT-1:0]
//             io_cfg_shift_en  - shift one configuration bit this cycle
//             io_cfg_sin       - serial configuration data in
//             io_cfg_sout      - serial configuration data out (chain to next tile)
//             io_cfg_commit    - copy shadow to active
//             io_cfg_full      - TOTAL bits shifted since last commit/reset
//             io_cfg_err       - last commit held a select field >= N_IN
//  Revision : 1.0 - initial release
// ============================================================================
module xbar_cfg #(
   parameter int N_IN    = 24,
   parameter int N_OUT   = 30,
   parameter int OUT_REG = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IN-1:0]  io_xbar_in,
   output logic [N_OUT-1:0] io_xbar_out,
   input  logic             io_cfg_shift_en,
   input  logic             io_cfg_sin,
   output logic             io_cfg_sout,
   input  logic             io_cfg_commit,
   output logic             io_cfg_full,
   output logic             io_cfg_err
);

   localparam int SEL_W = $clog2(N_IN);
   localparam int TOTAL = N_OUT * SEL_W;
   localparam int CNT_W = $clog2(TOTAL + 1);
   // Inputs are zero-padded to the full select range so an out-of-range
   // field reads a constant 0 instead of indexing past the real inputs.
   localparam int PAD_W = 1 << SEL_W;

   localparam logic [CNT_W-1:0] c_TOTAL = CNT_W'(TOTAL);
   localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);
   localparam logic [SEL_W:0]   c_N_IN  = (SEL_W + 1)'(N_IN);

   logic [TOTAL-1:0] r_shadow;
   logic [TOTAL-1:0] r_active;
   logic [CNT_W-1:0] r_count;
   logic             r_err;

   logic [TOTAL-1:0] w_shadow_shifted;
   logic             w_commit_err;
   logic [PAD_W-1:0] w_in_pad;
   logic [N_OUT-1:0] w_out_comb;

   // New bits enter at the top so the first bit sent ends up in bit 0.
   generate
      if (TOTAL > 1) begin : g_shift_wide
         assign w_shadow_shifted = {io_cfg_sin, r_shadow[TOTAL-1:1]};
      end else begin : g_shift_one
         assign w_shadow_shifted = io_cfg_sin;
      end
   endgenerate

   // Range check of the shadow contents, sampled into r_err at commit.
   always_comb begin
      w_commit_err = 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
         if ({1'b0, r_shadow[k*SEL_W +: SEL_W]} >= c_N_IN) begin
            w_commit_err = 1'b1;
         end
      end
   end

   // Shadow, active, counter and error flag. A commit coinciding with a
   // shift captures the pre-shift shadow and the shifted bit is the first
   // one counted towards the next load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shadow <= '0;
         r_active <= '0;
         r_count  <= '0;
         r_err    <= 1'b0;
      end else begin
         if (io_cfg_shift_en) begin
            r_shadow <= w_shadow_shifted;
         end
         if (io_cfg_commit) begin
            r_active <= r_shadow;
            r_err    <= w_commit_err;
            r_count  <= io_cfg_shift_en ? c_ONE : '0;
         end else if (io_cfg_shift_en && (r_count != c_TOTAL)) begin
            r_count  <= r_count + c_ONE;
         end
      end
   end

   generate
      if (PAD_W > N_IN) begin : g_pad
         assign w_in_pad = {{(PAD_W - N_IN){1'b0}}, io_xbar_in};
      end else begin : g_nopad
         assign w_in_pad = io_xbar_in;
      end
   endgenerate

   generate
      for (genvar k = 0; k < N_OUT; k++) begin : g_sel
         assign w_out_comb[k] = w_in_pad[r_active[k*SEL_W +: SEL_W]];
      end
   endgenerate

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [N_OUT-1:0] r_out;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_out <= '0;
            end else begin
               r_out <= w_out_comb;
            end
         end
         assign io_xbar_out = r_out;
      end else begin : g_out_comb
         assign io_xbar_out = w_out_comb;
      end
   endgenerate

   assign io_cfg_sout = r_shadow[0];
   assign io_cfg_full = (r_count == c_TOTAL);
   assign io_cfg_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_xbar_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xbar_cfg
//  Purpose  : Self-checking bench for xbar_cfg (defaults, OUT_REG=1). A small
//             behavioural model predicts outputs for every clock edge; the
//             predictions are queued when stimulus is driven and popped and
//             compared after the edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xbar_cfg;

   localparam int N_IN  = 24;
   localparam int N_OUT = 30;
   localparam int SEL_W = 5;
   localparam int TOTAL = 150;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [N_IN-1:0]  io_xbar_in = '0;
   logic [N_OUT-1:0] io_xbar_out;
   logic             io_cfg_shift_en = 1'b0;
   logic             io_cfg_sin = 1'b0;
   logic             io_cfg_sout;
   logic             io_cfg_commit = 1'b0;
   logic             io_cfg_full;
   logic             io_cfg_err;

   always #5 clk = ~clk;

   xbar_cfg #(.N_IN(N_IN), .N_OUT(N_OUT), .OUT_REG(1)) dut (
      .clk            (clk),
      .reset          (reset),
      .io_xbar_in     (io_xbar_in),
      .io_xbar_out    (io_xbar_out),
      .io_cfg_shift_en(io_cfg_shift_en),
      .io_cfg_sin     (io_cfg_sin),
      .io_cfg_sout    (io_cfg_sout),
      .io_cfg_commit  (io_cfg_commit),
      .io_cfg_full    (io_cfg_full),
      .io_cfg_err     (io_cfg_err)
   );

   typedef struct packed {
      logic [N_OUT-1:0] out;
      logic             sout;
      logic             full;
      logic             err;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   n_err = 0;
   int   n_chk = 0;

   // Behavioural model state
   logic [TOTAL-1:0] m_shadow = '0;
   logic [TOTAL-1:0] m_active = '0;
   int               m_count  = 0;
   logic             m_err    = 1'b0;

   function automatic logic [N_OUT-1:0] f_sel(input logic [TOTAL-1:0] a, input logic [N_IN-1:0] x);
      logic [N_OUT-1:0] o;
      int f;
      o = '0;
      for (int k = 0; k < N_OUT; k++) begin
         f = int'(a[k*SEL_W +: SEL_W]);
         if (f < N_IN) o[k] = x[f];
      end
      return o;
   endfunction

   function automatic logic f_err(input logic [TOTAL-1:0] s);
      logic r;
      r = 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
         if (int'(s[k*SEL_W +: SEL_W]) >= N_IN) r = 1'b1;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_shadow = '0;
      m_active = '0;
      m_count  = 0;
      m_err    = 1'b0;
   endtask

   // Drive one cycle of stimulus, predict the post-edge outputs, queue them,
   // then advance to just after the next rising edge.
   task automatic step(input logic sh, input logic sin, input logic cm, input logic [N_IN-1:0] xin);
      exp_t x;
      io_cfg_shift_en = sh;
      io_cfg_sin      = sin;
      io_cfg_commit   = cm;
      io_xbar_in      = xin;
      x.out = f_sel(m_active, xin);
      if (cm) begin
         m_active = m_shadow;
         m_err    = f_err(m_shadow);
         m_count  = sh ? 1 : 0;
      end else if (sh && m_count < TOTAL) begin
         m_count++;
      end
      if (sh) m_shadow = {sin, m_shadow[TOTAL-1:1]};
      x.sout = m_shadow[0];
      x.full = (m_count == TOTAL);
      x.err  = m_err;
      q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   // Shift a full TOTAL-bit vector, bit 0 first, comparing every cycle.
   task automatic shift_vec(input logic [TOTAL-1:0] v, input logic commit_last, input string tag);
      for (int i = 0; i < TOTAL; i++) begin
         step(1'b1, v[i], commit_last && (i == TOTAL - 1), N_IN'($urandom));
         e = q.pop_front();
         n_chk++;
         if ({io_xbar_out, io_cfg_sout, io_cfg_full, io_cfg_err} !== e) begin
            n_err++;
            $display("FAIL %s shift %0d: got out=%h sout=%b full=%b err=%b, want out=%h sout=%b full=%b err=%b",
                     tag, i, io_xbar_out, io_cfg_sout, io_cfg_full, io_cfg_err, e.out, e.sout, e.full, e.err);
         end
      end
   endtask

   task automatic test_reset();
      #12;
      io_xbar_in = 24'h000001;
      reset = 1'b1;
      #1;
      n_chk++;
      if (io_xbar_out !== 30'h0 || io_cfg_full !== 1'b0 || io_cfg_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_async: got out=%h full=%b err=%b, want 0 0 0", io_xbar_out, io_cfg_full, io_cfg_err);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      step(1'b0, 1'b0, 1'b0, 24'h000001);
      e = q.pop_front();
      n_chk++;
      if (io_xbar_out !== 30'h3FFFFFFF || io_xbar_out !== e.out) begin
         n_err++;
         $display("FAIL reset_release_out: got %h, want 3fffffff", io_xbar_out);
      end
   endtask

   task automatic test_full_load();
      logic [TOTAL-1:0] v;
      for (int k = 0; k < N_OUT; k++) v[k*SEL_W +: SEL_W] = SEL_W'(k % 24);
      shift_vec(v, 1'b0, "full_load");
      n_chk++;
      if (io_cfg_full !== 1'b1) begin
         n_err++;
         $display("FAIL full_before_commit: got %b, want 1", io_cfg_full);
      end
      step(1'b0, 1'b0, 1'b1, 24'h800001);
      e = q.pop_front();
      n_chk++;
      if ({io_xbar_out, io_cfg_sout, io_cfg_full, io_cfg_err} !== e || io_cfg_full !== 1'b0) begin
         n_err++;
         $display("FAIL full_commit_edge: got out=%h full=%b err=%b, want out=%h full=0 err=%b",
                  io_xbar_out, io_cfg_full, io_cfg_err, e.out, e.err);
      end
      step(1'b0, 1'b0, 1'b0, 24'h800001);
      e = q.pop_front();
      n_chk++;
      if (io_xbar_out !== 30'h1800001 || io_xbar_out !== e.out || io_cfg_err !== 1'b0) begin
         n_err++;
         $display("FAIL full_load_out: got out=%h err=%b, want 01800001 err=0", io_xbar_out, io_cfg_err);
      end
   endtask

   task automatic test_out_of_range();
      logic [TOTAL-1:0] v;
      v = '0;
      v[5*SEL_W +: SEL_W] = 5'd30;
      shift_vec(v, 1'b0, "oor_load");
      step(1'b0, 1'b0, 1'b1, '1);
      e = q.pop_front();
      n_chk++;
      if (io_cfg_err !== 1'b1 || io_cfg_err !== e.err) begin
         n_err++;
         $display("FAIL oor_err: got %b, want 1", io_cfg_err);
      end
      step(1'b0, 1'b0, 1'b0, '1);
      e = q.pop_front();
      n_chk++;
      if (io_xbar_out !== 30'h3FFFFFDF || io_xbar_out !== e.out || io_cfg_err !== 1'b1) begin
         n_err++;
         $display("FAIL oor_out: got out=%h err=%b, want 3fffffdf err=1", io_xbar_out, io_cfg_err);
      end
      shift_vec('0, 1'b0, "clean_load");
      n_chk++;
      if (io_cfg_err !== 1'b1) begin
         n_err++;
         $display("FAIL oor_err_hold: got %b, want 1", io_cfg_err);
      end
      step(1'b0, 1'b0, 1'b1, '1);
      e = q.pop_front();
      n_chk++;
      if (io_cfg_err !== 1'b0 || io_cfg_err !== e.err) begin
         n_err++;
         $display("FAIL clean_err: got %b, want 0", io_cfg_err);
      end
   endtask

   task automatic test_overlap();
      logic [TOTAL-1:0] v;
      logic [TOTAL-1:0] pre;
      logic [N_IN-1:0]  xin;
      for (int i = 0; i < TOTAL; i++) v[i] = 1'($urandom);
      // Shadow is all-zero from the clean load, so after 149 shifts it holds
      // v[148:0] above a single leftover 0 in bit 0.
      pre = {v[TOTAL-2:0], 1'b0};
      shift_vec(v, 1'b1, "overlap_load");
      n_chk++;
      if (io_cfg_full !== 1'b0) begin
         n_err++;
         $display("FAIL overlap_full: got %b, want 0", io_cfg_full);
      end
      xin = N_IN'($urandom);
      step(1'b0, 1'b0, 1'b0, xin);
      e = q.pop_front();
      n_chk++;
      if (io_xbar_out !== f_sel(pre, xin) || io_xbar_out !== e.out) begin
         n_err++;
         $display("FAIL overlap_active: got %h, want %h", io_xbar_out, f_sel(pre, xin));
      end
      // Count restarted at 1, so 149 more shifts fill it.
      for (int i = 0; i < TOTAL - 1; i++) begin
         step(1'b1, 1'($urandom), 1'b0, N_IN'($urandom));
         e = q.pop_front();
         n_chk++;
         if ({io_xbar_out, io_cfg_sout, io_cfg_full, io_cfg_err} !== e ||
             io_cfg_full !== (i == TOTAL - 2)) begin
            n_err++;
            $display("FAIL overlap_refill %0d: got out=%h sout=%b full=%b, want out=%h sout=%b full=%b",
                     i, io_xbar_out, io_cfg_sout, io_cfg_full, e.out, e.sout, e.full);
         end
      end
   endtask

   task automatic test_chain();
      logic sent[$];
      logic b;
      step(1'b0, 1'b0, 1'b1, '0);
      e = q.pop_front();
      for (int j = 1; j <= 2 * TOTAL; j++) begin
         b = 1'($urandom);
         sent.push_back(b);
         step(1'b1, b, 1'b0, N_IN'($urandom));
         e = q.pop_front();
         n_chk++;
         if ({io_xbar_out, io_cfg_sout, io_cfg_full, io_cfg_err} !== e ||
             io_cfg_full !== (j >= TOTAL) ||
             (j >= TOTAL && io_cfg_sout !== sent[j - TOTAL])) begin
            n_err++;
            $display("FAIL chain shift %0d: got sout=%b full=%b out=%h, want sout=%b full=%b out=%h",
                     j, io_cfg_sout, io_cfg_full, io_xbar_out, e.sout, e.full, e.out);
         end
      end
   endtask

   task automatic test_reset_mid_load();
      logic [TOTAL-1:0] v;
      v = '0;
      v[0 +: SEL_W] = 5'd31;
      shift_vec(v, 1'b0, "bad_load");
      step(1'b0, 1'b0, 1'b1, '1);
      e = q.pop_front();
      n_chk++;
      if (io_cfg_err !== 1'b1) begin
         n_err++;
         $display("FAIL midload_pre_err: got %b, want 1", io_cfg_err);
      end
      for (int i = 0; i < 70; i++) begin
         step(1'b1, 1'b1, 1'b0, N_IN'($urandom));
         e = q.pop_front();
      end
      #2;
      reset = 1'b1;
      #1;
      n_chk++;
      if (io_xbar_out !== 30'h0 || io_cfg_full !== 1'b0 || io_cfg_err !== 1'b0 || io_cfg_sout !== 1'b0) begin
         n_err++;
         $display("FAIL midload_reset: got out=%h full=%b err=%b sout=%b, want 0 0 0 0",
                  io_xbar_out, io_cfg_full, io_cfg_err, io_cfg_sout);
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      step(1'b0, 1'b0, 1'b1, '1);
      e = q.pop_front();
      n_chk++;
      if (io_cfg_err !== 1'b0 || io_cfg_full !== 1'b0) begin
         n_err++;
         $display("FAIL midload_commit: got err=%b full=%b, want 0 0", io_cfg_err, io_cfg_full);
      end
      step(1'b0, 1'b0, 1'b0, 24'h000001);
      e = q.pop_front();
      n_chk++;
      if (io_xbar_out !== 30'h3FFFFFFF || io_xbar_out !== e.out) begin
         n_err++;
         $display("FAIL midload_out: got %h, want 3fffffff", io_xbar_out);
      end
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_out_of_range();
      test_overlap();
      test_chain();
      test_reset_mid_load();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
